phy_rx_lane_destripe: RTL and testbench
=======================================

# phy_rx_lane_destripe

Parametrised multi-lane receive destriper for the PHY RX path. It takes byte streams from LANES serial-to-parallel converters, absorbs inter-lane skew in per-lane FIFOs, and reassembles byte-striped 32-bit words. It generalises the fixed two-lane, word-striped receive path to 1, 2 or 4 byte-striped lanes, and adds lane deskew, loss-of-lane recovery and error flags.

## Interface
- LANES, 2, number of lanes; legal values 1, 2, 4
- DEPTH, 4, per-lane deskew FIFO depth in bytes; power of 2, ≥2
- clk_4f  in  1  byte clock; single clock domain
- reset  in  1  asynchronous, active-high
- active_lane  in  LANES  per-lane active flag from each serial-to-parallel converter
- valid_lane  in  LANES  per-lane byte valid
- data_lane  in  8*LANES  lane i byte on [8i+7:8i]
- data_output  out  32  reassembled word
- valid_out  out  1  one-cycle pulse per completed word
- aligned  out  1  high while in RUN
- overflow  out  1  sticky; a byte was written to a full FIFO
- skew_err  out  1  sticky; skew exceeded DEPTH-1 cycles

## Operation
- State machine: IDLE, FILL, RUN.
- IDLE
  - FIFOs held empty; writes ignored; byte index = 0.
  - IDLE→FILL when &active_lane == 1.
- FILL
  - Writes accepted.
  - Skew counter starts at the first edge on which any FIFO is non-empty and increments each cycle.
  - When all FIFOs are non-empty: go to RUN and perform the first pop on that same edge.
  - If the counter reaches DEPTH first: set skew_err, flush FIFOs, go to IDLE.
- RUN
  - A pop happens on every edge on which every FIFO is non-empty.
  - Each pop removes one byte from each lane simultaneously.
- Any state except IDLE: if any active_lane bit is 0, go to IDLE, flush FIFOs, discard any partial word. No valid_out is produced for the partial word.
- Byte order
  - Word byte b = pop_index*LANES + lane.
  - Byte 0 lands in [31:24], byte 3 in [7:0].
  - Pops per word = 4/LANES.
- Byte index wraps modulo 4. The word completes on the pop that fills byte 3.
- FIFO occupancy ranges 0..DEPTH.
  - Simultaneous write and pop on a full FIFO: write accepted, no overflow.
  - Write to a full FIFO without a pop: byte dropped, overflow set.
- overflow and skew_err clear only on reset.

## Timing
- Reset values: data_output=0, valid_out=0, aligned=0, overflow=0, skew_err=0, state IDLE, FIFOs empty, byte index 0.
- Reset takes effect immediately (asynchronous), including mid-word.
- FIFO write occurs at the edge where valid_lane[i] is sampled. The byte is poppable from the next edge.
- With zero skew and the first bytes written at edge E0:
  - LANES=4: valid_out high after E0+1.
  - LANES=2: valid_out high after E0+2.
  - LANES=1: valid_out high after E0+4.
- Each additional cycle of lane skew adds one cycle of latency.
- data_output is registered and updates only with valid_out. It holds its value between words.
- valid_out is high for exactly one cycle per word.
- aligned rises on the edge entering RUN and falls on the edge leaving RUN.

## Test plan
- Zero skew, LANES=2: lane0 sends 0xAA, 0xBB and lane1 sends 0xCC, 0xDD on consecutive cycles → data_output=0xAACCBBDD, one valid_out pulse 2 cycles after the first byte, aligned=1.
- Skew within limit, LANES=2, DEPTH=4: lane1 starts 2 cycles after lane0 with the same data → identical word, valid_out 2 cycles later than the zero-skew case, skew_err=0.
- Skew over limit, DEPTH=4: lane1 silent for 4+ cycles after lane0's first byte → skew_err=1, state IDLE, no valid_out.
- Loss of lane mid-word, LANES=2: drop active_lane[0] after the first pop → aligned=0, no valid_out. After re-activation, the next 4 bytes yield the correct word.
- Overflow: in RUN, lane1 valid low for DEPTH+1 cycles while lane0 streams continuously → overflow=1 on the write at full, and overflow stays 1.
- LANES=4 continuous stream 0x00..0x0F → words 0x00010203 … 0x0C0D0E0F, one per cycle. Async reset mid-stream clears all outputs within the same cycle.

Source files
------------

// File: rtl/phy_rx_lane_destripe.sv
// phy_rx_lane_destripe: per-lane deskew FIFOs feeding a byte-striped 32-bit word assembler.
// Byte b of a word is pop_index*LANES + lane, with byte 0 landing in data_output[31:24].
module phy_rx_lane_destripe #(
    parameter int LANES = 2,
    parameter int DEPTH = 4
) (
    input  logic               clk_4f,
    input  logic               reset,
    input  logic [LANES-1:0]   active_lane,
    input  logic [LANES-1:0]   valid_lane,
    input  logic [8*LANES-1:0] data_lane,
    output logic [31:0]        data_output,
    output logic               valid_out,
    output logic               aligned,
    output logic               overflow,
    output logic               skew_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t         state;
    logic [7:0]     mem [LANES][DEPTH];
    logic [AW-1:0]  wptr [LANES];
    logic [AW-1:0]  rptr [LANES];
    logic [CW-1:0]  cnt [LANES];
    logic [CW-1:0]  skew_cnt;
    logic [1:0]     bidx;
    logic [31:0]    acc;
    logic [31:0]    nxt_acc;
    logic [LANES-1:0] ne;
    logic [LANES-1:0] full;
    logic [LANES-1:0] wr;
    logic [LANES-1:0] ovf;
    logic           all_act;
    logic           pop;
    logic           last;

    always_comb begin
        all_act = &active_lane;
        for (int l = 0; l < LANES; l++) begin
            ne[l]   = cnt[l] != '0;
            full[l] = cnt[l] == CW'(DEPTH);
        end
        pop = state != IDLE && all_act && &ne;
        // A full FIFO still takes a write when the same edge pops it.
        for (int l = 0; l < LANES; l++) begin
            wr[l]  = state != IDLE && all_act && valid_lane[l] && (!full[l] || pop);
            ovf[l] = state != IDLE && all_act && valid_lane[l] && full[l] && !pop;
        end
        nxt_acc = acc;
        for (int l = 0; l < LANES; l++)
            nxt_acc[8*(3-int'(bidx)-l) +: 8] = mem[l][rptr[l]];
        last = int'(bidx) + LANES == 4;
    end

    always_ff @(posedge clk_4f) begin
        for (int l = 0; l < LANES; l++)
            if (wr[l])
                mem[l][wptr[l]] <= data_lane[8*l +: 8];
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            data_output <= '0;
            valid_out   <= 1'b0;
            aligned     <= 1'b0;
            overflow    <= 1'b0;
            skew_err    <= 1'b0;
            skew_cnt    <= '0;
            bidx        <= '0;
            acc         <= '0;
            for (int l = 0; l < LANES; l++) begin
                wptr[l] <= '0;
                rptr[l] <= '0;
                cnt[l]  <= '0;
            end
        end else begin
            valid_out <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                if (wr[l])
                    wptr[l] <= wptr[l] + AW'(1);
                if (pop)
                    rptr[l] <= rptr[l] + AW'(1);
                cnt[l] <= cnt[l] + CW'(wr[l]) - CW'(pop);
            end
            if (|ovf)
                overflow <= 1'b1;
            if (pop) begin
                acc  <= nxt_acc;
                bidx <= bidx + 2'(LANES);
                if (last) begin
                    data_output <= nxt_acc;
                    valid_out   <= 1'b1;
                end
            end
            case (state)
                IDLE: if (all_act) begin
                    state    <= FILL;
                    skew_cnt <= '0;
                end
                FILL: if (&ne) begin
                    state   <= RUN;
                    aligned <= 1'b1;
                end else if (|ne) begin
                    if (skew_cnt == CW'(DEPTH - 1)) begin
                        skew_err <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        skew_cnt <= skew_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
            // Lane loss or excess skew: flush everything and drop any partial word.
            if ((state != IDLE && !all_act) ||
                (state == FILL && !(&ne) && |ne && skew_cnt == CW'(DEPTH - 1))) begin
                state     <= IDLE;
                aligned   <= 1'b0;
                valid_out <= 1'b0;
                bidx      <= '0;
                skew_cnt  <= '0;
                for (int l = 0; l < LANES; l++) begin
                    wptr[l] <= '0;
                    rptr[l] <= '0;
                    cnt[l]  <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_phy_rx_lane_destripe.sv
// tb_phy_rx_lane_destripe: directed checks of a 2-lane and a 4-lane destriper.
module tb_phy_rx_lane_destripe;
    logic        clk_4f = 1'b0;
    logic        reset  = 1'b1;
    logic [1:0]  act2 = '0, val2 = '0;
    logic [15:0] dat2 = '0;
    logic [31:0] do2;
    logic        vo2, al2, ov2, se2;
    logic [3:0]  act4 = '0, val4 = '0;
    logic [31:0] dat4 = '0;
    logic [31:0] do4;
    logic        vo4, al4, ov4, se4;
    int checks = 0;
    int errors = 0;

    always #5 clk_4f = ~clk_4f;

    phy_rx_lane_destripe #(.LANES(2), .DEPTH(4)) dut2 (
        .clk_4f(clk_4f), .reset(reset), .active_lane(act2), .valid_lane(val2),
        .data_lane(dat2), .data_output(do2), .valid_out(vo2), .aligned(al2),
        .overflow(ov2), .skew_err(se2));

    phy_rx_lane_destripe #(.LANES(4), .DEPTH(4)) dut4 (
        .clk_4f(clk_4f), .reset(reset), .active_lane(act4), .valid_lane(val4),
        .data_lane(dat4), .data_output(do4), .valid_out(vo4), .aligned(al4),
        .overflow(ov4), .skew_err(se4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_4f);
        #1;
    endtask

    initial begin
        step();
        chk("rst_do2", do2, 32'h0);
        chk("rst_vo2", {31'b0, vo2}, 32'h0);
        chk("rst_al2", {31'b0, al2}, 32'h0);
        chk("rst_ov2", {31'b0, ov2}, 32'h0);
        chk("rst_se2", {31'b0, se2}, 32'h0);
        chk("rst_do4", do4, 32'h0);
        reset = 1'b0;
        step();

        // zero skew
        act2 = 2'b11;
        step();
        val2 = 2'b11; dat2 = 16'hCCAA;
        step();
        chk("z_vo_e0", {31'b0, vo2}, 32'h0);
        dat2 = 16'hDDBB;
        step();
        chk("z_vo_e1", {31'b0, vo2}, 32'h0);
        chk("z_al_e1", {31'b0, al2}, 32'h1);
        val2 = 2'b00;
        step();
        chk("z_vo_e2", {31'b0, vo2}, 32'h1);
        chk("z_do_e2", do2, 32'hAACCBBDD);
        step();
        chk("z_vo_e3", {31'b0, vo2}, 32'h0);
        chk("z_do_hold", do2, 32'hAACCBBDD);

        // skew of 2 cycles
        act2 = 2'b00;
        step();
        chk("loss_al", {31'b0, al2}, 32'h0);
        act2 = 2'b11;
        step();
        val2 = 2'b01; dat2 = 16'h00AA;
        step();
        dat2 = 16'h00BB;
        step();
        val2 = 2'b10; dat2 = 16'hCC00;
        step();
        chk("s2_al_e2", {31'b0, al2}, 32'h0);
        dat2 = 16'hDD00;
        step();
        chk("s2_vo_e3", {31'b0, vo2}, 32'h0);
        chk("s2_al_e3", {31'b0, al2}, 32'h1);
        val2 = 2'b00;
        step();
        chk("s2_vo_e4", {31'b0, vo2}, 32'h1);
        chk("s2_do_e4", do2, 32'hAACCBBDD);
        chk("s2_se", {31'b0, se2}, 32'h0);

        // skew beyond limit
        act2 = 2'b00;
        step();
        act2 = 2'b11;
        step();
        val2 = 2'b01; dat2 = 16'h0055;
        step();
        val2 = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("sx_vo", {31'b0, vo2}, 32'h0);
        end
        chk("sx_se_e3", {31'b0, se2}, 32'h0);
        step();
        chk("sx_se_e4", {31'b0, se2}, 32'h1);
        chk("sx_al_e4", {31'b0, al2}, 32'h0);
        chk("sx_vo_e4", {31'b0, vo2}, 32'h0);

        // lane loss mid-word, then recovery
        act2 = 2'b00;
        step();
        act2 = 2'b11;
        step();
        val2 = 2'b11; dat2 = 16'h77EE;
        step();
        dat2 = 16'h8899;
        step();
        chk("ll_al_pop", {31'b0, al2}, 32'h1);
        val2 = 2'b00; act2 = 2'b10;
        step();
        chk("ll_al_drop", {31'b0, al2}, 32'h0);
        chk("ll_vo_drop", {31'b0, vo2}, 32'h0);
        step();
        chk("ll_vo_idle", {31'b0, vo2}, 32'h0);
        act2 = 2'b11;
        step();
        val2 = 2'b11; dat2 = 16'h2211;
        step();
        dat2 = 16'h4433;
        step();
        chk("ll_al_run", {31'b0, al2}, 32'h1);
        val2 = 2'b00;
        step();
        chk("ll_vo", {31'b0, vo2}, 32'h1);
        chk("ll_do", do2, 32'h11223344);

        // overflow: lane0 streams while lane1 is silent
        val2 = 2'b01;
        for (int i = 0; i < 4; i++) begin
            dat2 = 16'(8'h60 + i);
            step();
        end
        chk("ov_before", {31'b0, ov2}, 32'h0);
        step();
        chk("ov_at_full", {31'b0, ov2}, 32'h1);
        val2 = 2'b00;
        step();
        step();
        chk("ov_sticky", {31'b0, ov2}, 32'h1);
        chk("ov_se_sticky", {31'b0, se2}, 32'h1);

        // LANES=4 continuous stream
        act4 = 4'hF;
        step();
        val4 = 4'hF;
        for (int k = 0; k < 5; k++) begin
            for (int l = 0; l < 4; l++)
                dat4[8*l +: 8] = 8'(4*k + l);
            step();
            if (k == 0) begin
                chk("l4_vo_e0", {31'b0, vo4}, 32'h0);
            end else begin
                chk("l4_vo", {31'b0, vo4}, 32'h1);
                chk("l4_do", do4, {8'(4*k-4), 8'(4*k-3), 8'(4*k-2), 8'(4*k-1)});
            end
        end
        #2 reset = 1'b1;
        #1;
        chk("ar_do4", do4, 32'h0);
        chk("ar_vo4", {31'b0, vo4}, 32'h0);
        chk("ar_al4", {31'b0, al4}, 32'h0);
        chk("ar_ov2", {31'b0, ov2}, 32'h0);
        chk("ar_se2", {31'b0, se2}, 32'h0);
        chk("ar_do2", do2, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
